// File: rtl/timer_scheduler_if.sv
// timer_scheduler_if: request, timer and completion signals of the scheduler.
interface timer_scheduler_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
);
  logic in_valid, in_ready, flush, load, busy, done_valid;
  logic [WIDTH-1:0] in_cycles, cycles;
  logic [TAG_W-1:0] in_tag, done_tag;
  logic [$clog2(DEPTH+1)-1:0] pending;
  modport master (
    output in_valid, in_cycles, in_tag, flush, busy,
    input  in_ready, load, cycles, done_valid, done_tag, pending
  );
  modport slave (
    input  in_valid, in_cycles, in_tag, flush, busy,
    output in_ready, load, cycles, done_valid, done_tag, pending
  );
endinterface

// File: rtl/timer_scheduler.sv
// timer_scheduler: FIFO of tagged delay requests issued one at a time to the countdown timer.
module timer_scheduler #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  timer_scheduler_if.slave sched
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state_q;
  logic [TAG_W+WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic load_q, done_q, zero_q;
  logic [WIDTH-1:0] cycles_q, head_cycles;
  logic [TAG_W-1:0] done_tag_q, cur_tag_q, zero_tag_q, head_tag;
  logic empty, push, pop, head_zero;
  assign {head_tag, head_cycles} = mem_q[rd_q];
  assign empty = count_q == '0;
  assign head_zero = head_cycles == '0;
  assign push = sched.in_valid && sched.in_ready && !sched.flush;
  // a zero-cycle head completes without the timer, so IDLE pops it even while busy
  assign pop = !empty && ((state_q == IDLE) ? (!zero_q && (head_zero || !sched.busy))
                                            : (state_q == RUN && !sched.busy));
  assign sched.in_ready = count_q != CW'(DEPTH);
  assign sched.pending = count_q;
  assign sched.load = load_q;
  assign sched.cycles = cycles_q;
  assign sched.done_valid = done_q;
  assign sched.done_tag = done_tag_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {sched.in_tag, sched.in_cycles};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      load_q <= 1'b0;
      cycles_q <= '0;
      done_q <= 1'b0;
      done_tag_q <= '0;
      cur_tag_q <= '0;
      zero_q <= 1'b0;
      zero_tag_q <= '0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      if (sched.flush) begin
        wr_q <= '0;
        rd_q <= '0;
        count_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + AW'(1);
        if (pop) rd_q <= rd_q + AW'(1);
        if (push != pop) count_q <= push ? count_q + CW'(1) : count_q - CW'(1);
      end
      case (state_q)
        IDLE:
          if (zero_q) begin
            done_q <= 1'b1;
            done_tag_q <= zero_tag_q;
            zero_q <= 1'b0;
          end else if (pop && head_zero) begin
            done_q <= 1'b1;
            done_tag_q <= head_tag;
          end else if (pop) begin
            load_q <= 1'b1;
            cycles_q <= head_cycles;
            cur_tag_q <= head_tag;
            state_q <= LOAD;
          end
        LOAD: state_q <= RUN;
        default:
          if (!sched.busy) begin
            done_q <= 1'b1;
            done_tag_q <= cur_tag_q;
            state_q <= IDLE;
            // a zero head popped here reports its done from IDLE one cycle later
            if (pop && head_zero) begin
              zero_q <= 1'b1;
              zero_tag_q <= head_tag;
            end else if (pop) begin
              load_q <= 1'b1;
              cycles_q <= head_cycles;
              cur_tag_q <= head_tag;
              state_q <= LOAD;
            end
          end
      endcase
    end
endmodule
